// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The arbiter uses the master modport and the surrounding logic uses the slave modport.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_i;
  logic [8*NUM_REQ-1:0] byte_i;
  logic [NUM_REQ-1:0]   ack_o;
  logic                 tx_dv_o;
  logic [7:0]           tx_byte_o;
  logic                 tx_active_i;
  logic                 tx_done_i;
  logic                 busy_o;
  logic [2:0]           owner_o;
  logic                 timeout_o;

  modport master (
    input  req_i, byte_i, tx_active_i, tx_done_i,
    output ack_o, tx_dv_o, tx_byte_o, busy_o, owner_o, timeout_o
  );

  modport slave (
    output req_i, byte_i, tx_active_i, tx_done_i,
    input  ack_o, tx_dv_o, tx_byte_o, busy_o, owner_o, timeout_o
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte requesters.
// Optional macro UART_ARB_LOCK_EN keeps a grant on one requester for up to BURST_MAX bytes.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned TIMEOUT_CLKS = 4096,
  parameter int unsigned BURST_MAX    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned SEL_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CLKS < 2 || BURST_MAX < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_ready;
  logic               w_any_req;
  logic               w_wdog_hit;
  logic               w_launch;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_rr_sel;
  logic [SEL_W-1:0]   w_sel;
  logic [SEL_W-1:0]   w_scan_idx;
  logic [7:0]         w_sel_byte;
  logic [CNT_W-1:0]   r_wdog;

  logic [NUM_REQ-1:0] r_ack;
  logic [NUM_REQ-1:0] w_ack_nxt;
  logic               r_tx_dv;
  logic               w_tx_dv_nxt;
  logic [7:0]         r_tx_byte;
  logic [7:0]         w_tx_byte_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic [2:0]         r_owner;
  logic [2:0]         w_owner_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;

  assign w_ready    = ~bus.tx_active_i & ~bus.tx_done_i;
  assign w_any_req  = |bus.req_i;
  // Fires as the count steps onto TIMEOUT_CLKS-1, so the pulse and RELEASE coincide
  assign w_wdog_hit = (r_wdog == CNT_W'(TIMEOUT_CLKS - 2));
  assign w_launch   = (r_state == ST_IDLE) && (w_state_nxt == ST_LAUNCH);

  // Downward scan so the last hit is the lowest offset from r_rr_ptr
  always_comb begin
    w_rr_sel   = r_rr_ptr;
    w_scan_idx = r_rr_ptr;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      w_scan_idx = SEL_W'((32'(r_rr_ptr) + 32'(k)) % NUM_REQ);
      if (bus.req_i[w_scan_idx]) w_rr_sel = w_scan_idx;
    end
  end

`ifdef UART_ARB_LOCK_EN
  localparam int unsigned BURST_W = $clog2(BURST_MAX + 1);

  logic [BURST_W-1:0] r_burst;
  logic               w_lock_hit;

  assign w_lock_hit = bus.req_i[r_sel] && (r_burst < BURST_W'(BURST_MAX));
  assign w_sel      = w_lock_hit ? r_sel : w_rr_sel;

  // Bytes sent under the current grant; restarts at 1 whenever rotation picks the owner
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_burst <= '0;
    end else if (w_launch) begin
      r_burst <= w_lock_hit ? r_burst + BURST_W'(1) : BURST_W'(1);
    end
  end
`else
  assign w_sel = w_rr_sel;
`endif

  always_comb begin
    w_sel_byte = 8'h00;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_sel == SEL_W'(k)) w_sel_byte = bus.byte_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (w_ready && w_any_req) w_state_nxt = ST_LAUNCH;
      ST_LAUNCH:    w_state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (bus.tx_done_i || w_wdog_hit) w_state_nxt = ST_RELEASE;
      ST_RELEASE:   if (w_ready) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_ack_nxt     = '0;
    w_tx_dv_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_tx_byte_nxt = r_tx_byte;
    w_owner_nxt   = r_owner;
    if (w_launch) begin
      w_tx_dv_nxt      = 1'b1;
      w_ack_nxt[w_sel] = 1'b1;
      w_tx_byte_nxt    = w_sel_byte;
      w_owner_nxt      = 3'(w_sel);
    end
    if ((r_state == ST_WAIT_DONE) && !bus.tx_done_i && w_wdog_hit) w_timeout_nxt = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr  <= '0;
      r_sel     <= '0;
      r_wdog    <= '0;
      r_ack     <= '0;
      r_tx_dv   <= 1'b0;
      r_tx_byte <= 8'h00;
      r_busy    <= 1'b0;
      r_owner   <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_ack     <= w_ack_nxt;
      r_tx_dv   <= w_tx_dv_nxt;
      r_tx_byte <= w_tx_byte_nxt;
      r_busy    <= w_busy_nxt;
      r_owner   <= w_owner_nxt;
      r_timeout <= w_timeout_nxt;
      if (w_launch) r_sel <= w_sel;
      if (r_state == ST_LAUNCH) begin
        r_rr_ptr <= SEL_W'((32'(r_sel) + 32'd1) % NUM_REQ);
        r_wdog   <= '0;
      end else if (r_state == ST_WAIT_DONE) begin
        r_wdog   <= r_wdog + CNT_W'(1);
      end
    end
  end

  assign bus.ack_o     = r_ack;
  assign bus.tx_dv_o   = r_tx_dv;
  assign bus.tx_byte_o = r_tx_byte;
  assign bus.busy_o    = r_busy;
  assign bus.owner_o   = r_owner;
  assign bus.timeout_o = r_timeout;

endmodule
